sram_1rw_arbiter: RTL
=====================

// Module: sram_1rw_arbiter
// PURPOSE
//  Shares one single-port 1RW SRAM macro (2048x16, 1-cycle registered-address read) between a write
//  requester and a read requester. Valid/ready on both request channels; 2-entry response FIFO so
//  reads stream at 1/cycle under backpressure. Sits between pipeline logic and the *_ext macro wrapper.
// PARAMETERS
//  ADDR_W    11      SRAM address width
//  DATA_W    16      SRAM data width
//  DEPTH     2048    entries; equals 2**ADDR_W
//  INIT_VAL  0       word written to every entry by the init sweep (DATA_W bits)
// PORTS
//  clock        in   1       sole clock; also drives the macro RW0_clk
//  reset_n      in   1       asynchronous, active-low reset
//  wr_valid     in   1       write request
//  wr_ready     out  1       write accepted when wr_valid & wr_ready
//  wr_addr      in   ADDR_W  write address
//  wr_data      in   DATA_W  write data
//  rd_valid     in   1       read request
//  rd_ready     out  1       read accepted when rd_valid & rd_ready
//  rd_addr      in   ADDR_W  read address
//  resp_valid   out  1       read data available
//  resp_ready   in   1       consumer takes data when resp_valid & resp_ready
//  resp_data    out  DATA_W  read data, in request order
//  init_done    out  1       high once the block accepts requests
//  sram_en      out  1       to RW0_en
//  sram_wmode   out  1       to RW0_wmode
//  sram_addr    out  ADDR_W  to RW0_addr
//  sram_wdata   out  DATA_W  to RW0_wdata
//  sram_rdata   in   DATA_W  from RW0_rdata
// BEHAVIOUR
//  Reset: all outputs 0; FSM=INIT; resp FIFO empty; in-flight flag 0; last_win=WRITE.
//  FSM: INIT -> RUN when sweep ends (or immediately, see CONFIGURATION); RUN is terminal until reset.
//  INIT: wr_ready=rd_ready=0; sweep counter issues sram_en=1,wmode=1,addr=cnt,wdata=INIT_VAL,
//    cnt 0..DEPTH-1, one per cycle; after addr DEPTH-1, next cycle RUN and init_done=1 (registered).
//  RUN, one macro access per cycle, chosen combinationally:
//    rd_ok = occ + inflight - pop < 2   (occ = FIFO count, pop = resp_valid & resp_ready)
//    write only valid -> grant write; read only valid & rd_ok -> grant read.
//    both eligible -> grant opposite of last_win; last_win updates only on such a conflict.
//    read valid & !rd_ok -> write granted if valid; rd_ready=0.
//    wr_ready / rd_ready = grant of that channel; sram_* driven from the granted request, sram_en=0 idle.
//  Read latency: accepted cycle T -> macro rdata valid T+1 -> pushed into FIFO at end of T+1 ->
//    resp_valid earliest T+2. inflight = registered "read granted last cycle".
//  Ordering: read returns array contents before any write granted in a later cycle; write granted
//    the same cycle as an in-flight read's data phase does not corrupt it (macro rdata sampled at that edge).
//  FIFO full (occ=2) with no pop: no read granted; writes proceed. Simultaneous push+pop keeps occ.
//  Addresses are ADDR_W bits; no range check (DEPTH = 2**ADDR_W).
//  Reset mid-operation: in-flight read and FIFO contents discarded, INIT re-entered.
// CONFIGURATION
//  SRAM_ARB_INIT_SWEEP_EN defined: INIT sweep as above, DEPTH cycles, init_done rises cycle DEPTH+1.
//  Undefined: no sweep counter; FSM goes INIT->RUN on first clock after reset release; init_done=1
//    from cycle 1; SRAM contents undefined until written.
// STRUCTURE
//  Package sram_arb_pkg: state enum {INIT,RUN}, winner enum {WIN_RD,WIN_WR}, ADDR_W/DATA_W defaults.
//  Sub-module sram_arb_resp_fifo: 2-entry DATA_W FIFO, push/pop/occ/full/empty, async active-low reset.
//  Top: FSM, sweep counter, grant logic, inflight flag, macro port drive.
// TESTING
//  1 Sweep on: release reset -> 2048 writes of INIT_VAL, init_done at cycle 2049; read addr 0x7FF -> 0x0000.
//  2 Write 0x1234 @0x005 then read 0x005, resp_ready=1 -> resp_data 0x1234, resp_valid 2 cycles after rd accept.
//  3 wr_valid & rd_valid held 6 cycles -> grants alternate R,W,R,W,R,W starting with read.
//  4 resp_ready=0, stream reads @0..3 -> two accepted, rd_ready=0 afterward; writes still granted;
//    raise resp_ready -> data @0..3 in order, no loss or duplication.
//  5 Read 0x010 (old 0xAAAA) accepted T, write 0x5555 @0x010 granted T+1 -> resp 0xAAAA; next read -> 0x5555.
//  6 Assert reset_n=0 with 2 responses queued -> resp_valid=0 immediately, init restarts, FIFO empty.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the single-port SRAM arbiter slice.
//    arb_state_e : top-level controller state (INIT sweep / RUN arbitration)
//    winner_e    : which channel won the most recent read/write conflict
//    SRAM_ADDR_W / SRAM_DATA_W : default macro geometry (2048 x 16)
package sram_arb_pkg;

   localparam int SRAM_ADDR_W = 11;
   localparam int SRAM_DATA_W = 16;

   typedef enum logic {
      INIT,
      RUN
   } arb_state_e;

   typedef enum logic {
      WIN_RD,
      WIN_WR
   } winner_e;

endpackage

// File: rtl/sram_arb_resp_fifo.sv
// Two-entry response FIFO holding read data returned by the SRAM macro.
// Ports:
//    clock, reset_n   : clock, asynchronous active-low reset
//    push, push_data  : write one word (ignored when full without a pop)
//    pop, pop_data    : pop_data is the head word, consumed when pop is high
//    occ              : number of stored words (0..2)
//    full, empty      : occ == 2 / occ == 0
module sram_arb_resp_fifo
   import sram_arb_pkg::*;
#(
   parameter int DATA_W = SRAM_DATA_W
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic [1:0]        occ,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;
   logic              do_push;
   logic              do_pop;

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   // Pointers and occupancy; contents are dropped simply by clearing these.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: a word is only visible once count says so.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];
   assign occ      = count;
   assign full     = (count == 2'd2);
   assign empty    = (count == 2'd0);

endmodule

// File: rtl/sram_1rw_arbiter.sv
// Shares one 1RW SRAM macro (registered-address read, data one cycle later)
// between a write requester and a read requester, with a 2-entry response
// FIFO so reads can stream at one per cycle under backpressure.
// Ports:
//    clock, reset_n                     : clock (also the macro clock), async active-low reset
//    wr_valid/wr_ready/wr_addr/wr_data  : write request channel
//    rd_valid/rd_ready/rd_addr          : read request channel
//    resp_valid/resp_ready/resp_data    : read responses, in request order
//    init_done                          : high once requests are accepted
//    sram_en/sram_wmode/sram_addr/sram_wdata/sram_rdata : macro RW0 port
// Build option: define SRAM_ARB_INIT_SWEEP_EN to write INIT_VAL to every
// entry after reset before accepting requests; otherwise RUN is entered on
// the first clock after reset release and contents start undefined.
module sram_1rw_arbiter
   import sram_arb_pkg::*;
#(
   parameter int                ADDR_W   = SRAM_ADDR_W,
   parameter int                DATA_W   = SRAM_DATA_W,
   parameter int                DEPTH    = 2 ** ADDR_W,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              init_done,
   output logic              sram_en,
   output logic              sram_wmode,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
);

   arb_state_e        state, state_next;
   winner_e           last_win, last_win_next;
   logic              inflight;
   logic              grant_wr, grant_rd;
   logic              pop;
   logic [1:0]        occ;
   logic              fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_head;
   logic [2:0]        rd_load;
   logic              rd_ok;

   // Read data lands one cycle after the grant, so the in-flight read is
   // pushed straight from the macro output on the cycle it becomes valid.
   sram_arb_resp_fifo #(.DATA_W(DATA_W)) u_resp_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (inflight),
      .push_data (sram_rdata),
      .pop       (pop),
      .pop_data  (fifo_head),
      .occ       (occ),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign resp_valid = !fifo_empty;
   assign resp_data  = resp_valid ? fifo_head : '0;
   assign pop        = resp_valid && resp_ready;

   // A new read needs a FIFO slot that is still free once the in-flight read
   // lands; a pop this cycle frees one.
   assign rd_load = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   assign rd_ok   = fifo_full ? (pop && !inflight) : (rd_load < 3'd2);

`ifdef SRAM_ARB_INIT_SWEEP_EN
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic              sweep_go;
   logic [ADDR_W-1:0] sweep_cnt;

   // The sweep arms on the first clock after reset release and then writes
   // one address per cycle, so the macro sees nothing while reset is held.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sweep_go  <= 1'b0;
         sweep_cnt <= '0;
      end else if (state == INIT) begin
         sweep_go <= 1'b1;
         if (sweep_go) sweep_cnt <= sweep_cnt + 1'b1;
      end
   end
`endif

   // Controller state, conflict history and the read-in-flight marker.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= INIT;
         last_win <= WIN_WR;
         inflight <= 1'b0;
      end else begin
         state    <= state_next;
         last_win <= last_win_next;
         inflight <= grant_rd;
      end
   end

   // Grant selection and macro drive; one access per cycle.
   always_comb begin
      state_next    = state;
      last_win_next = last_win;
      grant_wr      = 1'b0;
      grant_rd      = 1'b0;
      sram_en       = 1'b0;
      sram_wmode    = 1'b0;
      sram_addr     = '0;
      sram_wdata    = '0;

      case (state)
         INIT: begin
`ifdef SRAM_ARB_INIT_SWEEP_EN
            if (sweep_go) begin
               sram_en    = 1'b1;
               sram_wmode = 1'b1;
               sram_addr  = sweep_cnt;
               sram_wdata = INIT_VAL;
               if (sweep_cnt == LAST_ADDR) state_next = RUN;
            end
`else
            state_next = RUN;
`endif
         end

         RUN: begin
            // Conflicts alternate; uncontested requests do not move last_win.
            if (wr_valid && rd_valid && rd_ok) begin
               if (last_win == WIN_WR) grant_rd = 1'b1;
               else                    grant_wr = 1'b1;
               last_win_next = grant_rd ? WIN_RD : WIN_WR;
            end else if (wr_valid) begin
               grant_wr = 1'b1;
            end else if (rd_valid && rd_ok) begin
               grant_rd = 1'b1;
            end

            if (grant_wr) begin
               sram_en    = 1'b1;
               sram_wmode = 1'b1;
               sram_addr  = wr_addr;
               sram_wdata = wr_data;
            end else if (grant_rd) begin
               sram_en    = 1'b1;
               sram_addr  = rd_addr;
            end
         end

         default: state_next = INIT;
      endcase
   end

   assign wr_ready  = grant_wr;
   assign rd_ready  = grant_rd;
   assign init_done = (state == RUN);

endmodule
